// File: rtl/mult_sa_nb.sv
// Unsigned n-by-n sequential shift-add multiplier: one ripple-carry adder,
// n add/shift steps per operation, 2n-bit registered product with a done pulse.

module rca_nb #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         c
);
  logic [n:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign c = cy[n];
endmodule

// Handshake: start is taken only while busy is low; done marks the single
// cycle in which prod has just been updated. start during busy is dropped.
module mult_sa_nb #(
  parameter int n = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] prod,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [n-1:0]   mcand_q, mcand_d;
  logic [n-1:0]   acc_q, acc_d;
  logic [n-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*n-1:0] prod_q, prod_d;

  logic [n-1:0]   addend;
  logic [n-1:0]   add_s;
  logic           add_c;

  assign addend = q_q[0] ? mcand_q : '0;

  rca_nb #(.n(n)) u_rca (
    .a   (acc_q),
    .b   (addend),
    .cin (1'b0),
    .s   (add_s),
    .c   (add_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Shift the (n+1)-bit sum right into q; the carry lands in acc[n-1].
        acc_d = {add_c, add_s[n-1:1]};
        q_d   = {add_s[0], q_q[n-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(n - 1)) begin
          prod_d  = {acc_d, q_d};
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign prod = prod_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
endmodule

// File: tb/tb_mult_sa_nb.sv
// Bench for mult_sa_nb at n=8 and n=16: directed scenarios plus random
// vectors checked against plain a*b products and an n-edge latency model.

module tb_mult_sa_nb;
  logic        clk = 1'b0;
  logic        rst;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, done8;

  logic        start16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        busy16, done16;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  mult_sa_nb #(.n(8)) dut8 (
    .CLK   (clk),
    .RST   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .prod  (p8),
    .busy  (busy8),
    .done  (done8)
  );

  mult_sa_nb #(.n(16)) dut16 (
    .CLK   (clk),
    .RST   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .prod  (p16),
    .busy  (busy16),
    .done  (done16)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called #1 after an edge with the DUT idle. Returns #1 after the edge
  // where done was first seen (lat = edges after acceptance, -1 on timeout).
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat,
                        output logic busy_e0);
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    busy_e0 = busy8;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    p = p8;
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat);
    start16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = -1;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      if (done16) begin lat = i; break; end
    end
    p = p16;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; start16 = 1'b1;
    a8 = 8'd5; b8 = 8'd5; a16 = 16'd5; b16 = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b0; start16 = 1'b0;
    n_checks++;
    if ({p8, busy8, done8} !== 18'd0) $display("FAIL reset8 got prod=%h busy=%b done=%b want 0/0/0", p8, busy8, done8);
    else n_pass++;
    n_checks++;
    if ({p16, busy16, done16} !== 34'd0) $display("FAIL reset16 got prod=%h busy=%b done=%b want 0/0/0", p16, busy16, done16);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat; logic be0;
    do_op8(8'd13, 8'd11, p, lat, be0);
    n_checks++;
    if (be0 !== 1'b1) $display("FAIL basic_busy_e0 got %b want 1", be0); else n_pass++;
    n_checks++;
    if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else n_pass++;
    n_checks++;
    if (p !== 16'h008F) $display("FAIL basic_prod got %h want 008f", p); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done8, busy8} !== 2'b00) $display("FAIL basic_after_done got done=%b busy=%b want 0/0", done8, busy8);
    else n_pass++;
  endtask

  task automatic test_carry();
    logic [15:0] p; int lat; logic be0;
    do_op8(8'hFF, 8'hFF, p, lat, be0);
    n_checks++;
    if (p !== 16'hFE01) $display("FAIL carry_ff_prod got %h want fe01", p); else n_pass++;
    @(posedge clk); #1;
    do_op8(8'h80, 8'h02, p, lat, be0);
    n_checks++;
    if (p !== 16'h0100) $display("FAIL carry_80x2_prod got %h want 0100", p); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_zeros();
    logic [15:0] p; int lat; logic be0;
    do_op8(8'd0, 8'd200, p, lat, be0);
    n_checks++;
    if (lat !== 8 || p !== 16'h0) $display("FAIL zero_a got lat=%0d prod=%h want 8/0000", lat, p); else n_pass++;
    @(posedge clk); #1;
    do_op8(8'd200, 8'd0, p, lat, be0);
    n_checks++;
    if (lat !== 8 || p !== 16'h0) $display("FAIL zero_b got lat=%0d prod=%h want 8/0000", lat, p); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int dones = 0; int first_done = -1;
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    for (int i = 0; i <= 24; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        dones++;
        if (first_done < 0) first_done = i;
      end
      start8 = 1'b0;
      // Attempts land on E3 (in RUN) and on the edge leaving DONE.
      if (i == 2 || (done8 && dones == 1)) begin start8 = 1'b1; a8 = 8'd7; b8 = 8'd7; end
    end
    start8 = 1'b0;
    n_checks++;
    if (first_done !== 8) $display("FAIL swb_latency got %0d want 8", first_done); else n_pass++;
    n_checks++;
    if (dones !== 1) $display("FAIL swb_done_count got %0d want 1", dones); else n_pass++;
    n_checks++;
    if (p8 !== 16'd15) $display("FAIL swb_prod got %0d want 15", p8); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int accepts[$]; logic prev = 1'b0; int bad_prod = 0;
    start8 = 1'b1; a8 = 8'd6; b8 = 8'd7;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy8 && !prev) accepts.push_back(i);
      if (done8 && p8 !== 16'd42) bad_prod++;
      prev = busy8;
    end
    start8 = 1'b0;
    n_checks++;
    if (accepts.size() !== 2) $display("FAIL b2b_accept_count got %0d want 2", accepts.size()); else n_pass++;
    while (accepts.size() < 2) accepts.push_back(-1);
    n_checks++;
    if (accepts[0] !== 0 || accepts[1] !== 10)
      $display("FAIL b2b_accept_edges got %0d,%0d want 0,10", accepts[0], accepts[1]);
    else n_pass++;
    n_checks++;
    if (bad_prod !== 0) $display("FAIL b2b_prod got %0d wrong products want 0", bad_prod); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int lat; logic be0; int spurious = 0;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    n_checks++;
    if ({p8, busy8, done8} !== 18'd0) $display("FAIL midrst_state got prod=%h busy=%b done=%b want 0/0/0", p8, busy8, done8);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) spurious++;
    end
    n_checks++;
    if (spurious !== 0) $display("FAIL midrst_quiet got %0d active cycles want 0", spurious); else n_pass++;
    do_op8(8'd2, 8'd3, p, lat, be0);
    n_checks++;
    if (lat !== 8 || p !== 16'd6) $display("FAIL midrst_fresh got lat=%0d prod=%0d want 8/6", lat, p); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    logic [31:0] p; int lat;
    do_op16(16'hFFFF, 16'hFFFF, p, lat);
    n_checks++;
    if (lat !== 16 || p !== 32'hFFFE0001) $display("FAIL wide_max got lat=%0d prod=%h want 16/fffe0001", lat, p);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] p; logic [31:0] p32; int lat; logic be0;
    logic [7:0] ra, rb; logic [15:0] wa, wb; logic [31:0] exp;
    for (int v = 0; v < 1000; v++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if (v % 50 == 0) ra = 8'hFF;
      exp_q.push_back(32'(ra) * 32'(rb));
      do_op8(ra, rb, p, lat, be0);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 8 || p !== exp[15:0])
        $display("FAIL rand8 a=%0d b=%0d got lat=%0d prod=%0d want 8/%0d", ra, rb, lat, p, exp[15:0]);
      else n_pass++;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    for (int v = 0; v < 200; v++) begin
      wa = 16'($urandom); wb = 16'($urandom);
      exp_q.push_back(32'(wa) * 32'(wb));
      do_op16(wa, wb, p32, lat);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 16 || p32 !== exp)
        $display("FAIL rand16 a=%0d b=%0d got lat=%0d prod=%0d want 16/%0d", wa, wb, lat, p32, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    test_reset();
    test_basic();
    test_carry();
    test_zeros();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
